// File: rtl/cadc_seq_if.sv
// Bus bundle between the conversion sequencer and its surroundings.
// The slave modport is the sequencer view. The master modport is the
// controller / analog-front-end / result-consumer view.
// With CADC_SEQ_CONT_EN defined, the bundle also carries the continuous-mode
// request 'cont'.
interface cadc_seq_if;
  logic              start;
  logic              abort;
  logic [2:0]        avg_log2;
  logic signed [7:0] dig_out;
  logic              sample;
  logic              busy;
  logic              res_valid;
  logic              res_ready;
  logic signed [7:0] res_data;
`ifdef CADC_SEQ_CONT_EN
  logic              cont;

  modport master (
    output start, abort, avg_log2, dig_out, res_ready, cont,
    input  sample, busy, res_valid, res_data
  );

  modport slave (
    input  start, abort, avg_log2, dig_out, res_ready, cont,
    output sample, busy, res_valid, res_data
  );
`else
  modport master (
    output start, abort, avg_log2, dig_out, res_ready,
    input  sample, busy, res_valid, res_data
  );

  modport slave (
    input  start, abort, avg_log2, dig_out, res_ready,
    output sample, busy, res_valid, res_data
  );
`endif
endinterface

// File: rtl/cadc_seq.sv
// Counter-ADC conversion sequencer.
// On start, it strobes the analog front-end 2^K times. Each strobe is tracked
// through the fixed LAT-cycle correction latency, and the aligned signed codes
// are summed. The sum is then shifted right by K and offered to the consumer
// over a valid/ready handshake.
// Optional feature macro: CADC_SEQ_CONT_EN. When it is defined, 'cont' lets
// HOLD restart a new burst directly at the handshake.
// LAT must be at least 2, because the last-code detection looks at the
// in-flight bits below the output tap.
module cadc_seq #(
  parameter int LAT     = 7,
  parameter int MAXLOG2 = 4
) (
  input logic      clk,
  input logic      rst,
  cadc_seq_if.slave bus
);

  localparam int AW = 8 + MAXLOG2;
  localparam int CW = MAXLOG2 + 1;
  localparam logic [2:0] MAXK = 3'(MAXLOG2);

  typedef enum logic [1:0] {IDLE, SAMPLE, DRAIN, HOLD} state_t;

  state_t state, state_next;

  logic [2:0]           k;
  logic [2:0]           k_clamped;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        n_val;
  logic [LAT-1:0]       inflight;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic signed [7:0]    res_data_q;

  logic tap;
  logic last_strobe;
  logic last_acc;
  logic sample_i;
  logic busy_i;
  logic valid_i;
  logic begin_burst;
  logic clr;
  logic load_res;

  assign k_clamped   = (bus.avg_log2 > MAXK) ? MAXK : bus.avg_log2;
  assign n_val       = CW'(1) << k;
  assign last_strobe = (cnt == n_val - CW'(1));
  assign tap         = inflight[LAT-1];
  // The code arriving at the tap is the final one when nothing else is still in flight behind it.
  assign last_acc    = tap && (inflight[LAT-2:0] == '0);
  assign acc_next    = tap ? (acc + {{(AW-8){bus.dig_out[7]}}, bus.dig_out}) : acc;

  assign bus.sample    = sample_i;
  assign bus.busy      = busy_i;
  assign bus.res_valid = valid_i;
  assign bus.res_data  = res_data_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and output decode; abort outranks the normal SAMPLE/DRAIN exits.
  always_comb begin
    state_next  = state;
    sample_i    = 1'b0;
    busy_i      = 1'b1;
    valid_i     = 1'b0;
    begin_burst = 1'b0;
    clr         = 1'b0;
    load_res    = 1'b0;
    case (state)
      IDLE: begin
        busy_i = 1'b0;
        if (bus.start) begin
          state_next  = SAMPLE;
          begin_burst = 1'b1;
        end
      end
      SAMPLE: begin
        sample_i = 1'b1;
        if (bus.abort) begin
          state_next = IDLE;
          clr        = 1'b1;
        end else if (last_strobe) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_next = IDLE;
          clr        = 1'b1;
        end else if (last_acc) begin
          state_next = HOLD;
          load_res   = 1'b1;
        end
      end
      HOLD: begin
        valid_i = 1'b1;
        if (bus.res_ready) begin
`ifdef CADC_SEQ_CONT_EN
          if (bus.cont) begin
            state_next  = SAMPLE;
            begin_burst = 1'b1;
          end else begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Burst datapath: the exponent latch, strobe counter, in-flight tracker, accumulator and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      k          <= '0;
      cnt        <= '0;
      inflight   <= '0;
      acc        <= '0;
      res_data_q <= '0;
    end else begin
      if (begin_burst) k <= k_clamped;

      if (begin_burst)   cnt <= '0;
      else if (sample_i) cnt <= cnt + CW'(1);

      if (clr) inflight <= '0;
      else     inflight <= {inflight[LAT-2:0], sample_i};

      if (clr || begin_burst) acc <= '0;
      else                    acc <= acc_next;

      if (load_res) res_data_q <= 8'(acc_next >>> k);
    end
  end

endmodule
